scanline_pingpong_ram: RTL and testbench

Parametrised, double-buffered scanline store for the PPU pixel path.
- The tile fetcher writes the next line into the back bank.
- The display side reads the current line from the front bank through a registered read port.
- A swap handshake exchanges the banks once the back bank is completely written.
- Replaces the single-bank, asynchronous-read 20x8 line buffer and adds bounds checking.

---
 rtl/scanline_pingpong_ram_if.sv | 26 ++
 rtl/scanline_pingpong_ram.sv | 51 +++++
 tb/tb_scanline_pingpong_ram.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/scanline_pingpong_ram_if.sv
// scanline_pingpong_ram_if: write, read and swap signals of the double-buffered scanline store
interface scanline_pingpong_ram_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              swap_req;
   logic              swap_ack;
   logic              front_bank;
   logic              back_full;
   logic              oob_err;
   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req,
      input  rd_data, rd_valid, swap_ack, front_bank, back_full, oob_err
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req,
      output rd_data, rd_valid, swap_ack, front_bank, back_full, oob_err
   );
endinterface

// File: rtl/scanline_pingpong_ram.sv
// scanline_pingpong_ram: two-bank scanline store; fetcher fills the back bank, display reads the front bank
module scanline_pingpong_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 20,
   parameter int ADDR_W = 5
) (
   input logic clk,
   input logic rst,
   scanline_pingpong_ram_if.slave bus
);
   typedef enum logic {IDLE, PENDING} state_t;
   localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];
   state_t state, stateNext;
   logic [DATA_W-1:0] mem [2][DEPTH];
   logic [DEPTH-1:0] bitmap, bitmapNext;
   logic wrIn, rdIn, swapNow;
   always_comb begin
      wrIn = {1'b0, bus.wr_addr} < LIMIT;
      rdIn = {1'b0, bus.rd_addr} < LIMIT;
      swapNow = bus.back_full && (state == PENDING || bus.swap_req);
      stateNext = swapNow ? IDLE : (bus.swap_req ? PENDING : state);
      // a write on the swap edge goes to the new front bank, so it is never tracked
      bitmapNext = swapNow ? '0 : bitmap | ((bus.wr_en && wrIn) ? DEPTH'(1) << bus.wr_addr : '0);
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= stateNext;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bitmap         <= '0;
         bus.front_bank <= 1'b0;
         bus.back_full  <= 1'b0;
         bus.swap_ack   <= 1'b0;
         bus.rd_data    <= '0;
         bus.rd_valid   <= 1'b0;
         bus.oob_err    <= 1'b0;
      end else begin
         bitmap         <= bitmapNext;
         bus.back_full  <= &bitmapNext;
         bus.front_bank <= bus.front_bank ^ swapNow;
         bus.swap_ack   <= swapNow;
         bus.rd_valid   <= bus.rd_en;
         if (bus.rd_en) bus.rd_data <= rdIn ? mem[bus.front_bank][bus.rd_addr] : '0;
         bus.oob_err    <= (bus.rd_en && !rdIn) || (bus.wr_en && !wrIn);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && bus.wr_en && wrIn) mem[~bus.front_bank][bus.wr_addr] <= bus.wr_data;
   end
endmodule

// File: tb/tb_scanline_pingpong_ram.sv
// tb_scanline_pingpong_ram: vector table plus read scoreboard for the double-buffered scanline store
module tb_scanline_pingpong_ram;
   typedef struct {
      bit       we;
      logic [4:0] wa;
      logic [7:0] wd;
      bit       re;
      logic [4:0] ra;
      bit       sr;
      logic [7:0] expRd;
      bit       expSwap;
      bit       expFull;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   scanline_pingpong_ram_if #(.DATA_W(8), .ADDR_W(5)) bus ();
   scanline_pingpong_ram #(.DATA_W(8), .DEPTH(20), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] rdQ[$];
   logic [7:0] lastRd = 8'h00;
   bit refFront = 1'b0;
   vec_t tbl[6];

   function automatic vec_t mk(int we, int wa, int wd, int re, int ra, int sr, int expRd, int expSwap, int expFull);
      vec_t v;
      v.we = we[0];
      v.wa = 5'(wa);
      v.wd = 8'(wd);
      v.re = re[0];
      v.ra = 5'(ra);
      v.sr = sr[0];
      v.expRd = 8'(expRd);
      v.expSwap = expSwap[0];
      v.expFull = expFull[0];
      return v;
   endfunction

   task automatic chk1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(vec_t v);
      logic [7:0] e;
      bus.wr_en = v.we;
      bus.wr_addr = v.wa;
      bus.wr_data = v.wd;
      bus.rd_en = v.re;
      bus.rd_addr = v.ra;
      bus.swap_req = v.sr;
      if (v.re) rdQ.push_back(v.expRd);
      @(posedge clk);
      #1;
      if (v.re) begin
         e = rdQ.pop_front();
         chk8("rd_data", bus.rd_data, e);
         chk1("rd_valid", bus.rd_valid, 1'b1);
         lastRd = e;
      end else begin
         chk1("rd_valid_idle", bus.rd_valid, 1'b0);
         chk8("rd_data_hold", bus.rd_data, lastRd);
      end
      chk1("oob_err", bus.oob_err, (v.we && v.wa >= 5'd20) || (v.re && v.ra >= 5'd20));
      chk1("swap_ack", bus.swap_ack, v.expSwap);
      refFront ^= v.expSwap;
      chk1("front_bank", bus.front_bank, refFront);
      chk1("back_full", bus.back_full, v.expFull);
   endtask

   task automatic wr(int a, int d, int full);
      step(mk(1, a, d, 0, 0, 0, 0, 0, full));
   endtask

   task automatic rd(int a, int exp);
      step(mk(0, 0, 0, 1, a, 0, exp, 0, 0));
   endtask

   task automatic req(int expSwap);
      step(mk(0, 0, 0, 0, 0, 1, 0, expSwap, 0));
   endtask

   task automatic idle(int expSwap, int full);
      step(mk(0, 0, 0, 0, 0, 0, 0, expSwap, full));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = mk(0, 0, 8'h00, 1, 25, 0, 8'h00, 0, 0);
      tbl[1] = mk(1, 20, 8'hFF, 0, 0, 0, 8'h00, 0, 0);
      tbl[2] = mk(0, 0, 8'h00, 1, 19, 0, 8'h23, 0, 0);
      tbl[3] = mk(1, 31, 8'hEE, 1, 20, 0, 8'h00, 0, 0);
      tbl[4] = mk(1, 3, 8'h55, 1, 3, 0, 8'h13, 0, 0);
      tbl[5] = mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);

      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.rd_en = 1'b0; bus.rd_addr = '0; bus.swap_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_front_bank", bus.front_bank, 1'b0);
      chk1("rst_back_full", bus.back_full, 1'b0);
      chk1("rst_rd_valid", bus.rd_valid, 1'b0);
      chk8("rst_rd_data", bus.rd_data, 8'h00);
      chk1("rst_swap_ack", bus.swap_ack, 1'b0);
      chk1("rst_oob_err", bus.oob_err, 1'b0);
      rst = 1'b0;

      // full line, immediate swap, read back
      for (int i = 0; i < 20; i++) wr(i, 8'hA0 + i, i == 19);
      req(1);
      for (int i = 0; i < 20; i++) rd(i, 8'hA0 + i);

      // partial line leaves the swap pending until the last address lands
      for (int i = 0; i < 19; i++) wr(i, 8'h10 + i, 0);
      req(0);
      idle(0, 0);
      idle(0, 0);
      wr(19, 8'h23, 1);
      idle(1, 0);

      // out-of-range accesses and same-address read/write across banks
      for (int i = 0; i < 6; i++) step(tbl[i]);
      for (int i = 0; i < 20; i++) if (i != 3) wr(i, 8'hC0 + i, i == 19);
      step(mk(1, 5, 8'h77, 1, 3, 1, 8'h13, 1, 0));
      rd(3, 8'h55);
      rd(5, 8'h77);
      rd(0, 8'hC0);
      rd(19, 8'hD3);

      // reset while pending abandons the swap
      for (int i = 0; i < 5; i++) wr(i, 8'h60 + i, 0);
      req(0);
      bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.rd_addr = 5'd0; bus.swap_req = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk1("rstp_front_bank", bus.front_bank, 1'b0);
      chk1("rstp_back_full", bus.back_full, 1'b0);
      chk1("rstp_swap_ack", bus.swap_ack, 1'b0);
      chk1("rstp_rd_valid", bus.rd_valid, 1'b0);
      chk8("rstp_rd_data", bus.rd_data, 8'h00);
      rst = 1'b0;
      refFront = 1'b0;
      lastRd = 8'h00;
      idle(0, 0);
      for (int i = 0; i < 20; i++) wr(i, 8'h80 + i, i == 19);
      idle(0, 1);
      idle(0, 1);
      req(1);
      rd(7, 8'h87);

      // repeated requests while pending collapse into one swap
      for (int i = 0; i < 10; i++) wr(i, 8'h30 + i, 0);
      req(0);
      req(0);
      idle(0, 0);
      req(0);
      for (int i = 10; i < 20; i++) wr(i, 8'h30 + i, i == 19);
      req(1);
      idle(0, 0);
      idle(0, 0);
      idle(0, 0);
      rd(12, 8'h3C);
      rd(19, 8'h43);
      idle(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
